// File: rtl/assoc_if.sv
// Handshake and result bundle between the memory-layer controller and assoc_layer.
`timescale 1ns/1ps
interface assoc_if #(
  parameter int W_WIDTH = 8
);
  logic               assoc_learning_start;
  logic [31:0]        c;
  logic               learning_done;
  logic               assoc_learning_done;
  logic               recall_req;
  logic [31:0]        recall_key;
  logic               recall_ready;
  logic               recall_valid;
  logic [31:0]        recall_class;
  logic [W_WIDTH-1:0] recall_weight;
  logic               class_err;

  modport slave (
    input  assoc_learning_start, c, learning_done, recall_req, recall_key,
    output assoc_learning_done, recall_ready, recall_valid, recall_class,
           recall_weight, class_err
  );

  modport master (
    output assoc_learning_start, c, learning_done, recall_req, recall_key,
    input  assoc_learning_done, recall_ready, recall_valid, recall_class,
           recall_weight, class_err
  );
endinterface

// File: rtl/assoc_layer.sv
// Class-to-class association matrix: learns prev->cur transitions with saturating
// weights and recalls the strongest successor of a key class by a row scan.
`timescale 1ns/1ps
module assoc_layer #(
  parameter int NUM_CLASS = 8,
  parameter int W_WIDTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  assoc_if.slave     bus,
  output logic [2:0] dbg_state_o
);

  localparam int IDX_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam logic [W_WIDTH-1:0] W_MAX   = {W_WIDTH{1'b1}};
  localparam logic [IDX_W-1:0]   IDX_END = IDX_W'(NUM_CLASS - 1);

  // Handshakes: assoc_learning_start is a level held until assoc_learning_done
  // is seen; a recall is accepted on a cycle where recall_req && recall_ready,
  // and the requester holds recall_req until then. Done/valid are 1-cycle pulses.
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_UPDATE, S_DONE, S_WAIT_LOW, S_RECALL, S_RESULT
  } state_t;

  state_t state_q, state_d;

  logic [W_WIDTH-1:0] assoc_w_q [NUM_CLASS][NUM_CLASS];
  logic [31:0]        cur_class_q;
  logic               in_range_q;
  logic [IDX_W-1:0]   prev_class_q;
  logic               prev_valid_q;
  logic [IDX_W-1:0]   key_idx_q;
  logic               key_ok_q;
  logic [IDX_W-1:0]   scan_idx_q;
  logic [W_WIDTH-1:0] best_w_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic               done_q;
  logic               valid_q;
  logic [31:0]        rclass_q;
  logic [W_WIDTH-1:0] rweight_q;
  logic               err_q;

  logic [IDX_W-1:0]   cur_idx;
  logic [W_WIDTH-1:0] scan_w;
  logic               start_accept;
  logic               recall_accept;

  // Unsigned compare also rejects negative int labels.
  function automatic logic class_ok(input logic [31:0] v);
    return v < 32'(NUM_CLASS);
  endfunction

  assign cur_idx       = cur_class_q[IDX_W-1:0];
  assign scan_w        = key_ok_q ? assoc_w_q[key_idx_q][scan_idx_q] : '0;
  assign start_accept  = (state_q == S_IDLE) && bus.assoc_learning_start;
  assign recall_accept = (state_q == S_IDLE) && !bus.assoc_learning_start && bus.recall_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.assoc_learning_start) state_d = S_CHECK;
        else if (bus.recall_req)      state_d = S_RECALL;
      end
      S_CHECK:    state_d = S_UPDATE;
      S_UPDATE:   state_d = S_DONE;
      S_DONE:     state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!bus.assoc_learning_start) state_d = S_IDLE;
      S_RECALL:   if (scan_idx_q == IDX_END) state_d = S_RESULT;
      S_RESULT:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_CLASS; r++) begin
        for (int k = 0; k < NUM_CLASS; k++) begin
          assoc_w_q[r][k] <= '0;
        end
      end
      cur_class_q  <= '0;
      in_range_q   <= 1'b0;
      prev_class_q <= '0;
      prev_valid_q <= 1'b0;
      key_idx_q    <= '0;
      key_ok_q     <= 1'b0;
      scan_idx_q   <= '0;
      best_w_q     <= '0;
      best_idx_q   <= '0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      rclass_q     <= '0;
      rweight_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      done_q  <= (state_q == S_DONE);
      valid_q <= (state_q == S_RESULT);

      if (start_accept) cur_class_q <= bus.c;

      if (state_q == S_CHECK) in_range_q <= class_ok(cur_class_q);

      if (state_q == S_UPDATE) begin
        if (in_range_q) begin
          if (prev_valid_q && (prev_class_q != cur_idx) &&
              (assoc_w_q[prev_class_q][cur_idx] != W_MAX)) begin
            assoc_w_q[prev_class_q][cur_idx] <= assoc_w_q[prev_class_q][cur_idx] + 1'b1;
          end
          prev_class_q <= cur_idx;
          prev_valid_q <= 1'b1;
        end else begin
          prev_valid_q <= 1'b0;
          err_q        <= 1'b1;
        end
      end

      // Sequence end only breaks the chain between requests, never mid-update.
      if (bus.learning_done && ((state_q == S_IDLE) || (state_q == S_WAIT_LOW))) begin
        prev_valid_q <= 1'b0;
      end

      if (recall_accept) begin
        key_idx_q  <= bus.recall_key[IDX_W-1:0];
        key_ok_q   <= class_ok(bus.recall_key);
        scan_idx_q <= '0;
        best_w_q   <= '0;
        best_idx_q <= '0;
      end

      // Strict greater-than keeps the lowest index on ties.
      if (state_q == S_RECALL) begin
        if (scan_w > best_w_q) begin
          best_w_q   <= scan_w;
          best_idx_q <= scan_idx_q;
        end
        scan_idx_q <= scan_idx_q + 1'b1;
      end

      if (state_q == S_RESULT) begin
        rclass_q  <= {{(32-IDX_W){1'b0}}, best_idx_q};
        rweight_q <= best_w_q;
        if (!key_ok_q) err_q <= 1'b1;
      end
    end
  end

  assign bus.recall_ready        = (state_q == S_IDLE) && !bus.assoc_learning_start;
  assign bus.assoc_learning_done = done_q;
  assign bus.recall_valid        = valid_q;
  assign bus.recall_class        = rclass_q;
  assign bus.recall_weight       = rweight_q;
  assign bus.class_err           = err_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_assoc_layer.sv
// Directed bench for assoc_layer: learning handshake, saturation, sequence
// breaks, out-of-range classes, held start, tie-breaking recall and reset.
`timescale 1ns/1ps
module tb_assoc_layer;
  localparam int NC = 8;
  localparam int WW = 8;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int total;
  int bad;

  assoc_if #(.W_WIDTH(WW)) bus ();

  assoc_layer #(.NUM_CLASS(NC), .W_WIDTH(WW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    bus.assoc_learning_start = 1'b0;
    bus.c                    = '0;
    bus.learning_done        = 1'b0;
    bus.recall_req           = 1'b0;
    bus.recall_key           = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drivers
  // One full learning handshake; lat counts edges from the sampling edge (edge k = 1).
  task automatic learn(input int cls, output int lat, output int pulses);
    lat = 0;
    pulses = 0;
    bus.assoc_learning_start = 1'b1;
    bus.c = cls;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.assoc_learning_done) begin
        pulses++;
        lat = i;
        break;
      end
    end
    bus.assoc_learning_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.assoc_learning_done) pulses++;
    end
  endtask

  task automatic seq_end();
    bus.learning_done = 1'b1;
    @(posedge clk); #1;
    bus.learning_done = 1'b0;
  endtask

  task automatic recall(input int key, output int cls, output int w, output int lat);
    cls = -1;
    w = -1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.recall_ready) break;
      @(posedge clk); #1;
    end
    bus.recall_req = 1'b1;
    bus.recall_key = key;
    @(posedge clk); #1;
    bus.recall_req = 1'b0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.recall_valid) begin
        lat = i;
        cls = int'(bus.recall_class);
        w = int'(bus.recall_weight);
        break;
      end
    end
  endtask

  // Tests
  task automatic test_reset();
    do_reset();
    total++; if (bus.assoc_learning_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.assoc_learning_done); end
    total++; if (bus.recall_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.recall_valid); end
    total++; if (bus.recall_class !== 32'd0) begin bad++; $display("FAIL reset_class got=%0d exp=0", bus.recall_class); end
    total++; if (bus.recall_weight !== 8'd0) begin bad++; $display("FAIL reset_weight got=%0d exp=0", bus.recall_weight); end
    total++; if (bus.class_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.class_err); end
    total++; if (bus.recall_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.recall_ready); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_basic();
    int lat, pulses, cls, w;
    do_reset();
    learn(2, lat, pulses);
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_done_lat got=%0d exp=4", lat); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", pulses); end
    learn(5, lat, pulses);
    total++; if (lat !== 4 || pulses !== 1) begin bad++; $display("FAIL basic_done2 lat=%0d pulses=%0d exp 4/1", lat, pulses); end
    recall(2, cls, w, lat);
    total++; if (cls !== 5 || w !== 1) begin bad++; $display("FAIL basic_recall got class=%0d w=%0d exp 5/1", cls, w); end
    total++; if (lat !== NC + 2) begin bad++; $display("FAIL basic_recall_lat got=%0d exp=%0d", lat, NC + 2); end
    recall(5, cls, w, lat);
    total++; if (cls !== 0 || w !== 0) begin bad++; $display("FAIL basic_empty_row got class=%0d w=%0d exp 0/0", cls, w); end
    total++; if (bus.class_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", bus.class_err); end
  endtask

  task automatic test_learning_done();
    int lat, pulses, cls, w;
    do_reset();
    learn(4, lat, pulses);
    seq_end();
    learn(6, lat, pulses);
    recall(4, cls, w, lat);
    total++; if (cls !== 0 || w !== 0) begin bad++; $display("FAIL seq_end_break got class=%0d w=%0d exp 0/0", cls, w); end
    learn(1, lat, pulses);
    recall(6, cls, w, lat);
    total++; if (cls !== 1 || w !== 1) begin bad++; $display("FAIL seq_end_resume got class=%0d w=%0d exp 1/1", cls, w); end
  endtask

  task automatic test_out_of_range();
    int lat, pulses, cls, w;
    do_reset();
    learn(7, lat, pulses);
    learn(9, lat, pulses);
    total++; if (lat !== 4 || pulses !== 1) begin bad++; $display("FAIL oor_done lat=%0d pulses=%0d exp 4/1", lat, pulses); end
    total++; if (bus.class_err !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", bus.class_err); end
    learn(3, lat, pulses);
    recall(7, cls, w, lat);
    total++; if (cls !== 0 || w !== 0) begin bad++; $display("FAIL oor_chain got class=%0d w=%0d exp 0/0", cls, w); end
    learn(-1, lat, pulses);
    learn(2, lat, pulses);
    recall(3, cls, w, lat);
    total++; if (cls !== 0 || w !== 0) begin bad++; $display("FAIL oor_negative got class=%0d w=%0d exp 0/0", cls, w); end
    do_reset();
    recall(20, cls, w, lat);
    total++; if (cls !== 0 || w !== 0 || lat !== NC + 2) begin bad++; $display("FAIL oor_key got class=%0d w=%0d lat=%0d exp 0/0/%0d", cls, w, lat, NC + 2); end
    total++; if (bus.class_err !== 1'b1) begin bad++; $display("FAIL oor_key_err got=%b exp=1", bus.class_err); end
  endtask

  task automatic test_start_held();
    int pulses;
    int ready_seen;
    do_reset();
    pulses = 0;
    ready_seen = 0;
    bus.assoc_learning_start = 1'b1;
    bus.c = 2;
    bus.recall_req = 1'b1;
    bus.recall_key = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.assoc_learning_done) pulses++;
      if (bus.recall_ready) ready_seen++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    total++; if (ready_seen !== 0) begin bad++; $display("FAIL held_ready got=%0d cycles exp=0", ready_seen); end
    total++; if (dbg_state !== 3'd4) begin bad++; $display("FAIL held_state got=%0d exp=4", dbg_state); end
    bus.recall_req = 1'b0;
    bus.assoc_learning_start = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.recall_ready !== 1'b1) begin bad++; $display("FAIL held_release_ready got=%b exp=1", bus.recall_ready); end
  endtask

  task automatic test_tie_and_reset();
    int lat, pulses, cls, w, vseen;
    do_reset();
    for (int i = 0; i < 3; i++) begin seq_end(); learn(0, lat, pulses); learn(1, lat, pulses); end
    for (int i = 0; i < 3; i++) begin seq_end(); learn(0, lat, pulses); learn(2, lat, pulses); end
    seq_end(); learn(0, lat, pulses); learn(3, lat, pulses);
    recall(0, cls, w, lat);
    total++; if (cls !== 1 || w !== 3) begin bad++; $display("FAIL tie_recall got class=%0d w=%0d exp 1/3", cls, w); end
    vseen = 0;
    bus.recall_req = 1'b1;
    bus.recall_key = 0;
    @(posedge clk); #1;
    bus.recall_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.recall_valid) vseen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.recall_valid) vseen++;
    end
    total++; if (vseen !== 0) begin bad++; $display("FAIL midscan_reset_valid got=%0d exp=0", vseen); end
    recall(0, cls, w, lat);
    total++; if (cls !== 0 || w !== 0 || lat !== NC + 2) begin bad++; $display("FAIL post_reset_recall got class=%0d w=%0d lat=%0d exp 0/0/%0d", cls, w, lat, NC + 2); end
  endtask

  task automatic test_saturation();
    int lat, pulses, cls, w;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      learn(1, lat, pulses);
      learn(3, lat, pulses);
      if (i == 254) begin
        recall(1, cls, w, lat);
        total++; if (cls !== 3 || w !== 255) begin bad++; $display("FAIL sat_reach got class=%0d w=%0d exp 3/255", cls, w); end
      end
    end
    recall(1, cls, w, lat);
    total++; if (cls !== 3 || w !== 255) begin bad++; $display("FAIL sat_hold got class=%0d w=%0d exp 3/255", cls, w); end
    recall(3, cls, w, lat);
    total++; if (cls !== 1 || w !== 255) begin bad++; $display("FAIL sat_reverse got class=%0d w=%0d exp 1/255", cls, w); end
  endtask

  // Sequence and report
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_learning_done();
    test_out_of_range();
    test_start_held();
    test_tie_and_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assoc_layer.md
ASSOC_LAYER -- requirements
Module: assoc_layer

Interface
REQ-001 Parameter NUM_CLASS, default 8, is the number of class nodes in the association matrix.
REQ-002 Parameter W_WIDTH, default 8, is the width of each association weight.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 assoc_learning_start  input  1  level request from the memory layer controller; held until done is seen.
REQ-006 c  input  32 (int)  class label of the current training sample; valid while assoc_learning_start is high.
REQ-007 learning_done  input  1  sequence end; clears the previous-class context.
REQ-008 assoc_learning_done  output  1  one-cycle pulse; the association update is complete.
REQ-009 recall_req  input  1  recall request for a key class.
REQ-010 recall_key  input  32 (int)  key class for recall.
REQ-011 recall_ready  output  1  recall request can be accepted this cycle.
REQ-012 recall_valid  output  1  one-cycle pulse; recall result is valid.
REQ-013 recall_class  output  32 (int)  associated response class.
REQ-014 recall_weight  output  W_WIDTH  weight of the returned association; 0 = none.
REQ-015 class_err  output  1  sticky flag; an out-of-range class was seen.

Function
REQ-016 Storage: assoc_w[NUM_CLASS][NUM_CLASS] of W_WIDTH-bit unsigned weights, plus registers prev_class and prev_valid.
REQ-017 FSM states: IDLE, CHECK, UPDATE, DONE, WAIT_LOW, RECALL, RESULT.
REQ-018 IDLE with assoc_learning_start=1 -> CHECK; c is latched into cur_class on the same edge.
REQ-019 CHECK -> UPDATE unconditionally; the range check 0<=cur_class<NUM_CLASS is evaluated here.
REQ-020 UPDATE, in range, prev_valid=1, prev_class!=cur_class: assoc_w[prev_class][cur_class] increments by 1 and saturates at 2^W_WIDTH-1 (no wrap).
REQ-021 UPDATE, in range: prev_class<=cur_class and prev_valid<=1; a self-association (prev_class==cur_class) writes no weight.
REQ-022 UPDATE, out of range: no matrix write, prev_valid<=0, class_err<=1; the handshake still completes.
REQ-023 DONE: assoc_learning_done=1 for exactly one cycle; if start was sampled at edge k, done is high between edges k+3 and k+4.
REQ-024 DONE -> WAIT_LOW; WAIT_LOW -> IDLE when assoc_learning_start=0; a still-high start is never treated as a new request.
REQ-025 learning_done=1 in IDLE or WAIT_LOW clears prev_valid on that edge; it is ignored in the other states.
REQ-026 recall_ready = (state==IDLE) && !assoc_learning_start; a request is accepted when recall_req && recall_ready.
REQ-027 When start and recall_req arrive in the same IDLE cycle, start wins; the recall request must be held by the requester.
REQ-028 RECALL scans row recall_key over indices 0..NUM_CLASS-1, one per cycle, tracking the maximum weight; on ties the lowest index is kept.
REQ-029 RESULT: recall_valid=1 for one cycle, with recall_class/recall_weight registered; if accepted at edge k, valid is high between edges k+NUM_CLASS+1 and k+NUM_CLASS+2; then -> IDLE.
REQ-030 All-zero row or out-of-range key: recall_class=0, recall_weight=0; an out-of-range key also sets class_err.
REQ-031 All outputs are registered except recall_ready.

Reset
REQ-032 reset=0 asynchronously forces: state IDLE, all assoc_w=0, prev_valid=0, prev_class=0, and all outputs 0 (recall_class=0).
REQ-033 Reset mid-operation abandons the update or scan with no partial write; the first request after release is handled normally.

Verification
REQ-034 Classes 2 then 5 (full handshakes) -> assoc_w[2][5]=1; done pulses once per request at k+3; recall key 2 -> class 5, weight 1 at k+9.
REQ-035 300 alternating 1->3 transitions with W_WIDTH=8 -> assoc_w[1][3] saturates at 255, no wrap.
REQ-036 Class 4 then learning_done then class 6 -> no association written; recall key 4 -> weight 0, class 0.
REQ-037 c=9 with NUM_CLASS=8 -> done still pulses, class_err=1, prev_valid=0, matrix unchanged.
REQ-038 Start held high through DONE for 5 cycles -> exactly one done pulse; recall_ready stays 0 until start falls.
REQ-039 Row 0 weights {0,3,3,1,...}, recall key 0 -> recall_class=1 (tie resolves to lowest index), weight 3; reset asserted mid-scan -> no recall_valid pulse.
